// File: rtl/n64_snac_pkg.sv
// Shared types and constants for the N64 SNAC joybus sequencer.
package n64_snac_pkg;

    typedef logic [5:0] cnt_t;
    typedef logic [7:0] byte_t;

    localparam int unsigned GapCyclesDefault = 160;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StSendWait,
        StSendNext,
        StRecv,
        StGap
    } snac_state_e;

    // Index of the byteRec that closes a transaction; a zero-length receive still
    // sees one stop-bit pulse.
    function automatic cnt_t last_rx_idx(input cnt_t recv_cnt);
        return (recv_cnt == '0) ? '0 : recv_cnt - cnt_t'(1);
    endfunction

endpackage

// File: rtl/n64_snac_sequencer_if.sv
// Joybus PHY control/status bundle between the sequencer (master) and the PHY (slave).
interface n64_snac_sequencer_if;
    import n64_snac_pkg::*;

    logic  phy_reset;
    logic  phy_start;
    byte_t phy_cmdData;
    cnt_t  phy_sendCnt;
    cnt_t  phy_receiveCnt;
    logic  phy_toPad_ena;
    logic  phy_ready;
    logic  phy_byteRec;
    byte_t phy_dataOut;
    logic  phy_timeout;

    modport master (
        output phy_reset, phy_start, phy_cmdData, phy_sendCnt, phy_receiveCnt, phy_toPad_ena,
        input  phy_ready, phy_byteRec, phy_dataOut, phy_timeout
    );

    modport slave (
        input  phy_reset, phy_start, phy_cmdData, phy_sendCnt, phy_receiveCnt, phy_toPad_ena,
        output phy_ready, phy_byteRec, phy_dataOut, phy_timeout
    );

endinterface

// File: rtl/n64_snac_rr_arb.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module n64_snac_rr_arb (
    input  logic       clk_1x,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    // Pointer starts at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_1x or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/n64_snac_sequencer.sv
// Arbitrates two joybus requesters and runs one send/receive transaction at a time
// through the PHY, enforcing an idle gap between transactions.
module n64_snac_sequencer
    import n64_snac_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = GapCyclesDefault
) (
    input  logic       clk_1x,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  cnt_t       send_cnt0,
    input  cnt_t       send_cnt1,
    input  cnt_t       recv_cnt0,
    input  cnt_t       recv_cnt1,
    output cnt_t       tx_idx,
    input  byte_t      tx_data0,
    input  byte_t      tx_data1,
    output logic       rx_we,
    output cnt_t       rx_idx,
    output byte_t      rx_data,
    output logic [1:0] done,
    output logic [1:0] err,
    n64_snac_sequencer_if.master phy
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    snac_state_e     state_q, state_d;
    logic [1:0]      gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic            rx_we_q, rx_we_d;
    cnt_t            rx_idx_q, rx_idx_d;
    byte_t           rx_data_q, rx_data_d;
    logic            phy_start_q, phy_start_d, to_pad_q, to_pad_d;
    byte_t           cmd_q, cmd_d;
    cnt_t            phy_send_q, phy_send_d, phy_recv_q, phy_recv_d;
    cnt_t            tx_idx_q, tx_idx_d, send_cnt_q, send_cnt_d, recv_cnt_q, recv_cnt_d;
    cnt_t            k_q, k_d;
    logic            seen_low_q, seen_low_d, next_phase_q, next_phase_d;
    logic            done_pend_q, done_pend_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic            phy_reset_q;
    logic            arb_advance;
    logic [1:0]      arb_gnt;
    byte_t           tx_sel;
    cnt_t            send_sel, recv_sel;

    n64_snac_rr_arb u_arb (
        .clk_1x  (clk_1x),
        .reset_n (reset_n),
        .req     (req),
        .advance (arb_advance),
        .grant   (arb_gnt)
    );

    assign tx_sel   = gnt_q[1] ? tx_data1 : tx_data0;
    assign send_sel = gnt_q[1] ? send_cnt1 : send_cnt0;
    assign recv_sel = gnt_q[1] ? recv_cnt1 : recv_cnt0;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        done_d       = '0;
        err_d        = '0;
        rx_we_d      = 1'b0;
        rx_idx_d     = rx_idx_q;
        rx_data_d    = rx_data_q;
        phy_start_d  = 1'b0;
        to_pad_d     = 1'b0;
        cmd_d        = cmd_q;
        phy_send_d   = phy_send_q;
        phy_recv_d   = phy_recv_q;
        tx_idx_d     = tx_idx_q;
        send_cnt_d   = send_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        k_d          = k_q;
        seen_low_d   = seen_low_q;
        next_phase_d = next_phase_q;
        done_pend_d  = done_pend_q;
        gap_cnt_d    = gap_cnt_q;
        arb_advance  = 1'b0;

        case (state_q)
            StIdle: begin
                tx_idx_d = '0;
                if (req != 2'b00) begin
                    gnt_d       = arb_gnt;
                    arb_advance = 1'b1;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                send_cnt_d = send_sel;
                recv_cnt_d = recv_sel;
                if (send_sel == '0) begin
                    err_d   = gnt_q;
                    state_d = StGap;
                end else begin
                    state_d = StStart;
                end
            end
            StStart: begin
                cmd_d       = tx_sel;
                phy_send_d  = send_cnt_q;
                phy_recv_d  = recv_cnt_q;
                phy_start_d = 1'b1;
                seen_low_d  = 1'b0;
                state_d     = StSendWait;
            end
            StSendWait: begin
                if (phy.phy_timeout) begin
                    err_d    = gnt_q;
                    tx_idx_d = '0;
                    state_d  = StGap;
                end else if (!seen_low_q) begin
                    seen_low_d = !phy.phy_ready;
                end else if (tx_idx_q >= send_cnt_q - cnt_t'(1)) begin
                    // Last byte is already with the PHY; it turns the bus around itself.
                    k_d     = '0;
                    state_d = StRecv;
                end else if (phy.phy_ready) begin
                    tx_idx_d     = tx_idx_q + cnt_t'(1);
                    next_phase_d = 1'b0;
                    state_d      = StSendNext;
                end
            end
            StSendNext: begin
                if (!next_phase_q) begin
                    next_phase_d = 1'b1;
                end else begin
                    cmd_d      = tx_sel;
                    to_pad_d   = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = StSendWait;
                end
            end
            StRecv: begin
                if (phy.phy_timeout) begin
                    err_d    = gnt_q;
                    tx_idx_d = '0;
                    state_d  = StGap;
                end else if (phy.phy_byteRec) begin
                    if (k_q < recv_cnt_q) begin
                        rx_we_d   = 1'b1;
                        rx_idx_d  = k_q;
                        rx_data_d = phy.phy_dataOut;
                    end
                    if (k_q == last_rx_idx(recv_cnt_q)) begin
                        done_pend_d = 1'b1;
                        tx_idx_d    = '0;
                        state_d     = StGap;
                    end else begin
                        k_d = k_q + cnt_t'(1);
                    end
                end
            end
            StGap: begin
                // done trails the final rx_we by one cycle; grant drops after done/err.
                if (done_pend_q) begin
                    done_d      = gnt_q;
                    done_pend_d = 1'b0;
                end else if (gnt_q != 2'b00) begin
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_1x or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            rx_we_q      <= 1'b0;
            rx_idx_q     <= '0;
            rx_data_q    <= '0;
            phy_start_q  <= 1'b0;
            to_pad_q     <= 1'b0;
            cmd_q        <= '0;
            phy_send_q   <= '0;
            phy_recv_q   <= '0;
            tx_idx_q     <= '0;
            send_cnt_q   <= '0;
            recv_cnt_q   <= '0;
            k_q          <= '0;
            seen_low_q   <= 1'b0;
            next_phase_q <= 1'b0;
            done_pend_q  <= 1'b0;
            gap_cnt_q    <= '0;
            phy_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rx_we_q      <= rx_we_d;
            rx_idx_q     <= rx_idx_d;
            rx_data_q    <= rx_data_d;
            phy_start_q  <= phy_start_d;
            to_pad_q     <= to_pad_d;
            cmd_q        <= cmd_d;
            phy_send_q   <= phy_send_d;
            phy_recv_q   <= phy_recv_d;
            tx_idx_q     <= tx_idx_d;
            send_cnt_q   <= send_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            k_q          <= k_d;
            seen_low_q   <= seen_low_d;
            next_phase_q <= next_phase_d;
            done_pend_q  <= done_pend_d;
            gap_cnt_q    <= gap_cnt_d;
            phy_reset_q  <= 1'b0;
        end
    end

    assign gnt                = gnt_q;
    assign done               = done_q;
    assign err                = err_q;
    assign rx_we              = rx_we_q;
    assign rx_idx             = rx_idx_q;
    assign rx_data            = rx_data_q;
    assign tx_idx             = tx_idx_q;
    assign phy.phy_reset      = phy_reset_q;
    assign phy.phy_start      = phy_start_q;
    assign phy.phy_cmdData    = cmd_q;
    assign phy.phy_sendCnt    = phy_send_q;
    assign phy.phy_receiveCnt = phy_recv_q;
    assign phy.phy_toPad_ena  = to_pad_q;

endmodule

// File: tb/tb_n64_snac_sequencer.sv
// Scoreboard bench for n64_snac_sequencer: stimulus queues expected events, a negedge
// monitor pops and compares them as the DUT produces them.
module tb_n64_snac_sequencer;

    localparam int unsigned GAP = 160;

    typedef enum logic [2:0] {EvGnt, EvStart, EvToPad, EvRx, EvDone, EvErr} ev_kind_e;
    typedef struct packed {
        ev_kind_e    kind;
        logic [19:0] val;
    } ev_t;

    logic       clk_1x = 1'b0;
    logic       reset_n;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [5:0] send_cnt0, send_cnt1, recv_cnt0, recv_cnt1;
    logic [5:0] tx_idx;
    logic [7:0] tx_data0, tx_data1;
    logic       rx_we;
    logic [5:0] rx_idx;
    logic [7:0] rx_data;
    logic [1:0] done, err;

    n64_snac_sequencer_if phy_bus ();

    n64_snac_sequencer #(.GAP_CYCLES(GAP)) dut (
        .clk_1x    (clk_1x),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .send_cnt0 (send_cnt0),
        .send_cnt1 (send_cnt1),
        .recv_cnt0 (recv_cnt0),
        .recv_cnt1 (recv_cnt1),
        .tx_idx    (tx_idx),
        .tx_data0  (tx_data0),
        .tx_data1  (tx_data1),
        .rx_we     (rx_we),
        .rx_idx    (rx_idx),
        .rx_data   (rx_data),
        .done      (done),
        .err       (err),
        .phy       (phy_bus)
    );

    always #5 clk_1x = ~clk_1x;

    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] tx_mem0 [64];
    logic [7:0] tx_mem1 [64];
    bit   pad_absent = 1'b0;

    // Requesters answer tx_idx with one cycle of latency.
    always @(posedge clk_1x) begin
        tx_data0 <= tx_mem0[tx_idx];
        tx_data1 <= tx_mem1[tx_idx];
    end

    // Behavioural joybus PHY.
    initial begin : phy_model
        int nsend, nrecv, nbytes;
        phy_bus.phy_ready   = 1'b1;
        phy_bus.phy_byteRec = 1'b0;
        phy_bus.phy_dataOut = 8'h00;
        phy_bus.phy_timeout = 1'b0;
        forever begin
            @(posedge clk_1x); #1;
            if (phy_bus.phy_start === 1'b1) begin
                nsend = int'(phy_bus.phy_sendCnt);
                nrecv = int'(phy_bus.phy_receiveCnt);
                phy_bus.phy_ready = 1'b0;
                for (int s = 1; s < nsend; s++) begin
                    repeat (3) @(posedge clk_1x);
                    #1 phy_bus.phy_ready = 1'b1;
                    for (int n = 0; n < 20; n++) begin
                        @(posedge clk_1x); #1;
                        if (phy_bus.phy_toPad_ena === 1'b1) break;
                    end
                    phy_bus.phy_ready = 1'b0;
                end
                repeat (4) @(posedge clk_1x);
                #1;
                if (pad_absent) begin
                    phy_bus.phy_timeout = 1'b1;
                    @(posedge clk_1x); #1 phy_bus.phy_timeout = 1'b0;
                end else begin
                    nbytes = (nrecv == 0) ? 1 : nrecv;
                    for (int b = 0; b < nbytes; b++) begin
                        phy_bus.phy_byteRec = 1'b1;
                        phy_bus.phy_dataOut = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
                        @(posedge clk_1x); #1 phy_bus.phy_byteRec = 1'b0;
                        repeat (3) @(posedge clk_1x);
                        #1;
                    end
                end
                phy_bus.phy_ready = 1'b1;
            end
        end
    end

    task automatic observe(input ev_kind_e k, input logic [19:0] v);
        ev_t e;
        bit  ok;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s got %h expected none", k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == EvErr && k == EvErr && e.val[9:2] == 8'hFF) ok = (e.val[1:0] == v[1:0]);
            else ok = (e.kind == k) && (e.val == v);
            if (!ok) begin
                errors++;
                $display("FAIL event_%s got %s %h expected %s %h", e.kind.name(), k.name(), v,
                         e.kind.name(), e.val);
            end
        end
    endtask

    // Monitor: every DUT output event is matched against the head of the scoreboard.
    int         cyc = 0;
    int         gnt_cyc = 0;
    int         low_cnt = 0;
    bit         had_grant = 1'b0;
    logic [1:0] prev_gnt = 2'b00;
    always @(negedge clk_1x) begin
        int off;
        if (!reset_n) begin
            had_grant = 1'b0;
            prev_gnt  = 2'b00;
            low_cnt   = 0;
        end else begin
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                if (had_grant) begin
                    checks++;
                    if (low_cnt < GAP) begin
                        errors++;
                        $display("FAIL gap_len got %0d expected >= %0d", low_cnt, GAP);
                    end
                end
                observe(EvGnt, 20'(gnt));
                gnt_cyc   = cyc;
                had_grant = 1'b1;
            end
            low_cnt  = (gnt == 2'b00) ? low_cnt + 1 : 0;
            prev_gnt = gnt;
            if (phy_bus.phy_start) begin
                observe(EvStart, {phy_bus.phy_sendCnt, phy_bus.phy_receiveCnt, phy_bus.phy_cmdData});
            end
            if (phy_bus.phy_toPad_ena) observe(EvToPad, 20'(phy_bus.phy_cmdData));
            if (rx_we) observe(EvRx, 20'({rx_idx, rx_data}));
            if (done != 2'b00) observe(EvDone, 20'(done));
            if (err != 2'b00) begin
                off = cyc - gnt_cyc;
                observe(EvErr, 20'({(off > 254) ? 8'hFE : 8'(off), err}));
            end
        end
        cyc++;
    end

    task automatic expect_ev(input ev_kind_e k, input logic [19:0] v);
        exp_q.push_back('{kind: k, val: v});
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_1x);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending events expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_gnt"}, 32'(gnt), 32'h0);
        check_val({tag, "_done_err"}, 32'({done, err}), 32'h0);
        check_val({tag, "_strobes"}, 32'({rx_we, phy_bus.phy_start, phy_bus.phy_toPad_ena}), 32'h0);
        check_val({tag, "_idx"}, 32'({tx_idx, rx_idx}), 32'h0);
        check_val({tag, "_phy_regs"},
                  32'({phy_bus.phy_cmdData, phy_bus.phy_sendCnt, phy_bus.phy_receiveCnt}), 32'h0);
        check_val({tag, "_phy_reset"}, 32'(phy_bus.phy_reset), 32'h1);
    endtask

    initial begin : stimulus
        int n;
        reset_n   = 1'b0;
        req       = 2'b00;
        send_cnt0 = '0;
        send_cnt1 = '0;
        recv_cnt0 = '0;
        recv_cnt1 = '0;
        for (int i = 0; i < 64; i++) begin
            tx_mem0[i] = 8'(i);
            tx_mem1[i] = 8'(8'h80 + i);
        end
        tx_mem0[0] = 8'h01;
        tx_mem1[0] = 8'h13;
        tx_mem1[1] = 8'hA5;
        tx_mem1[2] = 8'h3C;

        repeat (3) @(negedge clk_1x);
        check_reset_outputs("por");
        reset_n = 1'b1;
        #1 check_val("phy_reset_hold", 32'(phy_bus.phy_reset), 32'h1);
        @(negedge clk_1x);
        check_val("phy_reset_release", 32'(phy_bus.phy_reset), 32'h0);

        // Status poll: 1 byte out, 4 bytes back.
        send_cnt0 = 6'd1; recv_cnt0 = 6'd4;
        resp_q = '{8'h05, 8'h00, 8'h02, 8'h80};
        expect_ev(EvGnt, 20'h1);
        expect_ev(EvStart, {6'd1, 6'd4, 8'h01});
        expect_ev(EvRx, 20'({6'd0, 8'h05}));
        expect_ev(EvRx, 20'({6'd1, 8'h00}));
        expect_ev(EvRx, 20'({6'd2, 8'h02}));
        expect_ev(EvRx, 20'({6'd3, 8'h80}));
        expect_ev(EvDone, 20'h1);
        req = 2'b01;
        drain(500);
        req = 2'b00;

        // Illegal zero-length send: err one cycle after LOAD, PHY untouched.
        send_cnt0 = 6'd0; recv_cnt0 = 6'd2;
        expect_ev(EvGnt, 20'h1);
        expect_ev(EvErr, 20'({8'd1, 2'b01}));
        req = 2'b01;
        drain(500);
        req = 2'b00;

        // Pad absent: timeout after start.
        send_cnt0 = 6'd1; recv_cnt0 = 6'd4;
        pad_absent = 1'b1;
        expect_ev(EvGnt, 20'h1);
        expect_ev(EvStart, {6'd1, 6'd4, 8'h01});
        expect_ev(EvErr, 20'({8'hFF, 2'b01}));
        req = 2'b01;
        drain(500);
        req = 2'b00;
        repeat (10) @(negedge clk_1x);
        pad_absent = 1'b0;

        // Three-byte send from requester 1.
        send_cnt1 = 6'd3; recv_cnt1 = 6'd1;
        resp_q = '{8'h77};
        expect_ev(EvGnt, 20'h2);
        expect_ev(EvStart, {6'd3, 6'd1, 8'h13});
        expect_ev(EvToPad, 20'h000A5);
        expect_ev(EvToPad, 20'h0003C);
        expect_ev(EvRx, 20'({6'd0, 8'h77}));
        expect_ev(EvDone, 20'h2);
        req = 2'b10;
        drain(500);
        req = 2'b00;

        // Both requesting: grants alternate 0,1,0,1.
        send_cnt0 = 6'd1; recv_cnt0 = 6'd1;
        send_cnt1 = 6'd1; recv_cnt1 = 6'd1;
        resp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 4; i++) begin
            expect_ev(EvGnt, (i % 2 == 0) ? 20'h1 : 20'h2);
            expect_ev(EvStart, {6'd1, 6'd1, (i % 2 == 0) ? 8'h01 : 8'h13});
            expect_ev(EvRx, 20'({6'd0, 8'(8'hA0 + i)}));
            expect_ev(EvDone, (i % 2 == 0) ? 20'h1 : 20'h2);
        end
        req = 2'b11;
        drain(3000);
        req = 2'b00;

        // Zero-length receive: the stop-bit pulse completes without rx_we.
        send_cnt0 = 6'd1; recv_cnt0 = 6'd0;
        resp_q = '{8'h5A};
        expect_ev(EvGnt, 20'h1);
        expect_ev(EvStart, {6'd1, 6'd0, 8'h01});
        expect_ev(EvDone, 20'h1);
        req = 2'b01;
        drain(500);
        req = 2'b00;

        // Reset in the middle of a 3-byte receive.
        recv_cnt0 = 6'd3;
        resp_q = '{8'h11, 8'h22, 8'h33};
        expect_ev(EvGnt, 20'h1);
        expect_ev(EvStart, {6'd1, 6'd3, 8'h01});
        expect_ev(EvRx, 20'({6'd0, 8'h11}));
        req = 2'b01;
        drain(500);
        reset_n = 1'b0;
        req     = 2'b00;
        @(negedge clk_1x);
        check_reset_outputs("mid_rx");
        @(negedge clk_1x);
        reset_n = 1'b1;
        #1 check_val("phy_reset_hold2", 32'(phy_bus.phy_reset), 32'h1);
        @(negedge clk_1x);
        check_val("phy_reset_release2", 32'(phy_bus.phy_reset), 32'h0);
        repeat (30) @(negedge clk_1x);
        resp_q.delete();

        // Back in IDLE: a new request is granted on the very next edge.
        recv_cnt0 = 6'd1;
        resp_q = '{8'h44};
        expect_ev(EvGnt, 20'h1);
        expect_ev(EvStart, {6'd1, 6'd1, 8'h01});
        expect_ev(EvRx, 20'({6'd0, 8'h44}));
        expect_ev(EvDone, 20'h1);
        req = 2'b01;
        n = 0;
        while (gnt == 2'b00 && n < 10) begin
            @(negedge clk_1x);
            n++;
        end
        check_val("post_reset_grant_latency", 32'(n), 32'd1);
        drain(500);
        req = 2'b00;
        repeat (20) @(negedge clk_1x);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/n64_snac_sequencer.md
N64_SNAC_SEQUENCER -- requirements
Module: n64_snac_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 160, minimum clk_1x cycles of bus idle between transactions.
REQ-002 SHALL have these ports, clock and reset first; clock is clk_1x and reset is reset_n: one clock; reset is asynchronous and active-low.
- clk_1x in 1: the only clock.
- reset_n in 1: asynchronous, active-low reset.
- req in 2: transaction request, one bit per requester (0 = PIF path, 1 = auto-poller); level, held until done/err.
- gnt out 2: one-hot grant, high for the whole transaction.
- send_cnt0, send_cnt1 in 6: bytes to send per requester; sampled at grant.
- recv_cnt0, recv_cnt1 in 6: bytes expected back per requester; sampled at grant.
- tx_idx out 6: byte index requested from the granted requester.
- tx_data0, tx_data1 in 8: requester byte at tx_idx, valid 1 cycle after tx_idx changes.
- rx_we out 1: receive-byte write strobe.
- rx_idx out 6: index of the received byte.
- rx_data out 8: received byte.
- done out 2: 1-cycle pulse, transaction completed.
- err out 2: 1-cycle pulse, timeout or illegal send_cnt.
- phy_reset out 1: reset to the joybus PHY.
- phy_start out 1: start pulse to the PHY.
- phy_cmdData out 8: current transmit byte to the PHY.
- phy_sendCnt out 6: byte count to the PHY.
- phy_receiveCnt out 6: expected receive count to the PHY.
- phy_toPad_ena out 1: next-byte pulse to the PHY.
- phy_ready in 1: PHY ready.
- phy_byteRec in 1: PHY byte-received pulse.
- phy_dataOut in 8: PHY received byte.
- phy_timeout in 1: PHY timeout pulse.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, START, SEND_WAIT, SEND_NEXT, RECV, GAP.
REQ-004 In IDLE with any req bit set, arbitration SHALL be round-robin: the requester not granted last wins a tie; grant is registered and held until the cycle after done/err.
REQ-005 LOAD SHALL latch send_cnt/recv_cnt of the winner, drive tx_idx=0, and hold one cycle so tx_data is valid.
REQ-006 LOAD with latched send_cnt==0 SHALL pulse err for the winner, skip the PHY, and go to GAP.
REQ-007 START SHALL drive phy_cmdData=tx_data[gnt], phy_sendCnt, and phy_receiveCnt, pulse phy_start 1 cycle, then go to SEND_WAIT.
REQ-008 phy_cmdData SHALL be held stable from START until the next SEND_NEXT load.
REQ-009 SEND_WAIT SHALL first observe phy_ready==0.
REQ-010 In SEND_WAIT, a subsequent phy_ready 0->1 with tx_idx < send_cnt-1 SHALL go to SEND_NEXT; otherwise the sequencer SHALL go directly to RECV without waiting for phy_ready.
REQ-011 SEND_NEXT SHALL increment tx_idx, wait 1 cycle, load phy_cmdData, pulse phy_toPad_ena 1 cycle, and return to SEND_WAIT.
REQ-012 In RECV, each phy_byteRec SHALL increment a pulse count k (0-based).
REQ-013 In RECV, if k < recv_cnt, the sequencer SHALL assert rx_we the next cycle with rx_idx=k and rx_data=phy_dataOut.
REQ-014 When recv_cnt==0, the single stop-bit phy_byteRec SHALL produce no rx_we.
REQ-015 The transaction SHALL complete on the phy_byteRec with k == max(recv_cnt,1)-1: pulse done[gnt] 1 cycle after the last rx_we, then go to GAP.
REQ-016 phy_timeout in SEND_WAIT or RECV SHALL pulse err[gnt], suppress done, and go to GAP.
REQ-017 phy_byteRec or phy_timeout outside RECV/SEND_WAIT SHALL be ignored.
REQ-018 GAP SHALL count GAP_CYCLES cycles with gnt=0, then return to IDLE; a req held high SHALL be re-arbitrated only after GAP.
REQ-019 A req bit dropping mid-transaction SHALL NOT abort the transaction; done/err SHALL still pulse.
REQ-020 All counters SHALL be 6 bits and SHALL NOT wrap, since counts are bounded by send_cnt/recv_cnt <= 63.

Reset
REQ-021 While reset_n=0: state=IDLE, gnt=0, done=0, err=0, rx_we=0, phy_start=0, phy_toPad_ena=0, tx_idx=0, rx_idx=0, phy_cmdData=0, phy_sendCnt=0, phy_receiveCnt=0, phy_reset=1, round-robin pointer=requester 1 (so requester 0 wins the first tie).
REQ-022 phy_reset SHALL deassert one registered cycle after reset_n rises.
REQ-023 Reset mid-transaction SHALL abort with no done/err pulse.

Structure
REQ-024 State encoding and the GAP_CYCLES default SHALL live in the shared package n64_snac_pkg.
REQ-025 The round-robin arbiter SHALL be one sub-module, n64_snac_rr_arb.

Verification
REQ-026 req=01, send_cnt0=1, recv_cnt0=4, PHY model returns 05 00 02 80 -> rx_we x4 with rx_idx 0..3 and those bytes, then done[0] x1.
REQ-027 req=11 held -> grants alternate 0,1,0,1, with gnt low for >=160 cycles between grants.
REQ-028 send_cnt1=3, tx bytes 13 A5 3C -> phy_cmdData sequence 13,A5,3C; exactly 2 phy_toPad_ena pulses; phy_start x1.
REQ-029 Pad absent (phy_timeout after start) -> err[0] x1, no done, no rx_we, then GAP.
REQ-030 send_cnt0=0 -> err[0] the cycle after LOAD; phy_start never asserts.
REQ-031 recv_cnt=0 with one phy_byteRec -> no rx_we, done pulse; reset_n low mid-RECV -> all outputs at reset values, IDLE next.
